// File: rtl/parity_pkg.sv
// Shared types and constants for the odd-parity serial receive path.
package parity_pkg;

    localparam int unsigned SYM_W    = 8;
    localparam int unsigned DATA_W   = 7;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned CONSEC_W = 4;
    localparam logic        IDLE_LVL = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_e;

endpackage

// File: rtl/parity_odd_chk.sv
// Combinational odd-parity checker: flags a symbol whose bits XOR to 0.
module parity_odd_chk
    import parity_pkg::*;
(
    input  logic [SYM_W-1:0] sym,
    output logic             isErr
);

    assign isErr = ~^sym;

endmodule

// File: rtl/parity_frame_ctrl.sv
// Odd-parity symbol receiver: start-bit hunt, 8-bit shift-in, stop check,
// parity check and saturating error statistics with a sticky alarm.
module parity_frame_ctrl
    import parity_pkg::*;
#(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned ALARM_TH = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bitIn,
    input  logic              bitValid,
    input  logic              errClr,
    output logic              symValid,
    output logic [DATA_W-1:0] symData,
    output logic              symErr,
    output logic              frameErr,
    output logic [CNT_W-1:0]  errCnt,
    output logic              alarm
);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [SYM_W-1:0]    shreg_q, shreg_d;
    logic                sym_valid_q, sym_valid_d;
    logic [DATA_W-1:0]   sym_data_q, sym_data_d;
    logic                sym_err_q, sym_err_d;
    logic                frame_err_q, frame_err_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic [CONSEC_W-1:0] consec_q, consec_d;
    logic                alarm_q, alarm_d;
    logic                sym_is_err;

    parity_odd_chk u_chk (
        .sym   (shreg_q),
        .isErr (sym_is_err)
    );

    // Frame FSM; only advances on bitValid cycles.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        sym_valid_d = 1'b0;
        sym_data_d  = sym_data_q;
        sym_err_d   = sym_err_q;
        frame_err_d = 1'b0;
        if (bitValid) begin
            case (state_q)
                IDLE: begin
                    if (bitIn != IDLE_LVL) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end
                DATA: begin
                    shreg_d = {shreg_q[SYM_W-2:0], bitIn};
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(SYM_W - 1)) begin
                        state_d = STOP;
                    end
                end
                STOP: begin
                    if (bitIn == IDLE_LVL) begin
                        sym_valid_d = 1'b1;
                        sym_data_d  = shreg_q[SYM_W-1:1];
                        sym_err_d   = sym_is_err;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Statistics trail the presented symbol by one cycle; a clear always wins.
    always_comb begin
        err_cnt_d = err_cnt_q;
        consec_d  = consec_q;
        alarm_d   = alarm_q;
        if (errClr) begin
            err_cnt_d = '0;
            consec_d  = '0;
            alarm_d   = 1'b0;
        end else if (sym_valid_q) begin
            if (sym_err_q) begin
                if (err_cnt_q != {CNT_W{1'b1}}) begin
                    err_cnt_d = err_cnt_q + CNT_W'(1);
                end
                if (consec_q != {CONSEC_W{1'b1}}) begin
                    consec_d = consec_q + CONSEC_W'(1);
                end
                if (consec_d >= CONSEC_W'(ALARM_TH)) begin
                    alarm_d = 1'b1;
                end
            end else begin
                consec_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            shreg_q     <= '0;
            sym_valid_q <= 1'b0;
            sym_data_q  <= '0;
            sym_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
            consec_q    <= '0;
            alarm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            sym_valid_q <= sym_valid_d;
            sym_data_q  <= sym_data_d;
            sym_err_q   <= sym_err_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
            consec_q    <= consec_d;
            alarm_q     <= alarm_d;
        end
    end

    assign symValid = sym_valid_q;
    assign symData  = sym_data_q;
    assign symErr   = sym_err_q;
    assign frameErr = frame_err_q;
    assign errCnt   = err_cnt_q;
    assign alarm    = alarm_q;

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Randomised bench for parity_frame_ctrl: two instances (wide and 2-bit counter)
// checked every cycle against a frame-level model, plus literal spot checks.
module tb_parity_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bitIn = 1'b1;
    logic       bitValid = 1'b0;
    logic       errClr = 1'b0;

    logic       sv_a, se_a, fe_a, al_a;
    logic [6:0] sd_a;
    logic [7:0] ec_a;
    logic       sv_b, se_b, fe_b, al_b;
    logic [6:0] sd_b;
    logic [1:0] ec_b;

    always #5 clk = ~clk;

    parity_frame_ctrl #(.CNT_W(8), .ALARM_TH(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .bitIn(bitIn), .bitValid(bitValid), .errClr(errClr),
        .symValid(sv_a), .symData(sd_a), .symErr(se_a), .frameErr(fe_a),
        .errCnt(ec_a), .alarm(al_a)
    );

    parity_frame_ctrl #(.CNT_W(2), .ALARM_TH(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bitIn(bitIn), .bitValid(bitValid), .errClr(errClr),
        .symValid(sv_b), .symData(sd_b), .symErr(se_b), .frameErr(fe_b),
        .errCnt(ec_b), .alarm(al_b)
    );

    int checks = 0;
    int failures = 0;
    bit done = 1'b0;

    // Reference model: collect the 10 line bits of a frame, then decode it.
    bit       line_q[$];
    bit       m_valid = 1'b0;
    bit       m_err = 1'b0;
    bit       m_ferr = 1'b0;
    bit [6:0] m_data = 7'h00;
    int       m_cnt[2];
    int       m_run[2];
    bit       m_alarm[2];

    function automatic int cnt_max(int k);
        return (k == 0) ? 255 : 3;
    endfunction

    function automatic int alarm_th(int k);
        return (k == 0) ? 3 : 2;
    endfunction

    always @(posedge clk) begin
        bit       pv;
        bit       pe;
        bit [7:0] s;
        if (!rst_n) begin
            line_q.delete();
            m_valid = 1'b0; m_err = 1'b0; m_ferr = 1'b0; m_data = 7'h00;
            for (int k = 0; k < 2; k++) begin
                m_cnt[k] = 0; m_run[k] = 0; m_alarm[k] = 1'b0;
            end
        end else begin
            pv = m_valid;
            pe = m_err;
            for (int k = 0; k < 2; k++) begin
                if (errClr) begin
                    m_cnt[k] = 0; m_run[k] = 0; m_alarm[k] = 1'b0;
                end else if (pv) begin
                    if (pe) begin
                        if (m_cnt[k] < cnt_max(k)) m_cnt[k] = m_cnt[k] + 1;
                        if (m_run[k] < 15) m_run[k] = m_run[k] + 1;
                        if (m_run[k] >= alarm_th(k)) m_alarm[k] = 1'b1;
                    end else begin
                        m_run[k] = 0;
                    end
                end
            end
            m_valid = 1'b0;
            m_ferr  = 1'b0;
            if (bitValid) begin
                if (!(line_q.size() == 0 && bitIn)) line_q.push_back(bitIn);
                if (line_q.size() == 10) begin
                    if (line_q[9]) begin
                        for (int i = 0; i < 8; i++) s[7-i] = line_q[1+i];
                        m_data  = s[7:1];
                        m_err   = ~^s;
                        m_valid = 1'b1;
                    end else begin
                        m_ferr = 1'b1;
                    end
                    line_q.delete();
                end
            end
        end
    end

    task automatic cmp(string nm, bit v, bit [6:0] d, bit e, bit f, int c, bit a, int k);
        checks++;
        if (v !== m_valid || d !== m_data || e !== m_err || f !== m_ferr ||
            c != m_cnt[k] || a !== m_alarm[k]) begin
            failures++;
            $display("FAIL %s t=%0t got v=%0b d=%h e=%0b f=%0b cnt=%0d al=%0b exp v=%0b d=%h e=%0b f=%0b cnt=%0d al=%0b",
                     nm, $time, v, d, e, f, c, a, m_valid, m_data, m_err, m_ferr, m_cnt[k], m_alarm[k]);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (!done) begin
            cmp("model_a", sv_a, sd_a, se_a, fe_a, int'(ec_a), al_a, 0);
            cmp("model_b", sv_b, sd_b, se_b, fe_b, int'(ec_b), al_b, 1);
        end
    end

    task automatic chk(string nm, int got, int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic drive(bit v, bit b, bit c);
        @(negedge clk);
        bitValid = v;
        bitIn    = b;
        errClr   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(bit b, int gap);
        repeat (gap) drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, b, 1'b0);
    endtask

    task automatic send_frame(bit [6:0] d, bit p, bit stop, int gap);
        send_bit(1'b0, gap);
        for (int i = 6; i >= 0; i--) send_bit(d[i], gap);
        send_bit(p, gap);
        send_bit(stop, gap);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit [6:0] rd;
        rst_n = 1'b0;
        repeat (2) drive(1'b0, 1'b1, 1'b0);
        chk("reset_symValid", int'(sv_a), 0);
        chk("reset_symData", int'(sd_a), 0);
        chk("reset_errCnt", int'(ec_a), 0);
        chk("reset_alarm", int'(al_a), 0);
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0);

        send_frame(7'h55, 1'b0, 1'b1, 0);
        chk("f1_symValid", int'(sv_a), 1);
        chk("f1_symData", int'(sd_a), 'h55);
        chk("f1_symErr", int'(se_a), 1);
        drive(1'b0, 1'b1, 1'b0);
        chk("f1_errCnt", int'(ec_a), 1);

        send_frame(7'h55, 1'b1, 1'b1, 0);
        chk("f2_symData", int'(sd_a), 'h55);
        chk("f2_symErr", int'(se_a), 0);
        drive(1'b0, 1'b1, 1'b0);
        chk("f2_errCnt_hold", int'(ec_a), 1);

        repeat (3) send_frame(7'h55, 1'b0, 1'b1, 0);
        drive(1'b0, 1'b1, 1'b0);
        chk("run3_alarm", int'(al_a), 1);
        chk("run3_errCnt", int'(ec_a), 4);
        chk("run3_errCnt_sat2", int'(ec_b), 3);
        send_frame(7'h55, 1'b1, 1'b1, 0);
        drive(1'b0, 1'b1, 1'b0);
        chk("good_alarm_sticky", int'(al_a), 1);
        drive(1'b0, 1'b1, 1'b1);
        chk("clr_alarm", int'(al_a), 0);
        chk("clr_errCnt", int'(ec_a), 0);

        send_frame(7'h2A, 1'b1, 1'b0, 0);
        chk("stop0_frameErr", int'(fe_a), 1);
        chk("stop0_symValid", int'(sv_a), 0);
        chk("stop0_symData_held", int'(sd_a), 'h55);
        drive(1'b0, 1'b1, 1'b0);
        chk("stop0_errCnt", int'(ec_a), 0);

        send_frame(7'h00, 1'b1, 1'b1, 3);
        chk("slow_symValid", int'(sv_a), 1);
        chk("slow_symData", int'(sd_a), 0);
        chk("slow_symErr", int'(se_a), 0);

        send_bit(1'b0, 0);
        send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
        rst_n = 1'b0;
        repeat (2) drive(1'b0, 1'b1, 1'b0);
        chk("midrst_symData", int'(sd_a), 0);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b0);
        send_frame(7'h3C, 1'b1, 1'b1, 0);
        chk("postrst_symData", int'(sd_a), 'h3C);
        chk("postrst_symErr", int'(se_a), 0);

        repeat (5) send_frame(7'h01, 1'b1, 1'b1, 0);
        drive(1'b0, 1'b1, 1'b0);
        chk("sat_errCnt_b", int'(ec_b), 3);
        chk("sat_errCnt_a", int'(ec_a), 5);

        for (int n = 0; n < 300; n++) begin
            rd = 7'($urandom);
            repeat ($urandom_range(0, 2)) drive(1'b1, 1'b1, 1'b0);
            send_frame(rd, 1'($urandom), ($urandom_range(0, 7) != 0), $urandom_range(0, 1));
            drive(1'b0, 1'b1, ($urandom_range(0, 5) == 0));
        end

        repeat (3) drive(1'b0, 1'b1, 1'b0);
        done = 1'b1;
        drive(1'b0, 1'b1, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/parity_frame_ctrl.md
# parity_frame_ctrl

Serial-link receive controller for the odd-parity symbol path. It hunts for start bits on a sampled serial line and shifts in 8-bit symbols (7 data bits plus 1 odd-parity bit). Each symbol is checked against its stop bit and passed through the odd-parity checker; the block reports each symbol with its error flag and maintains error statistics. It sits between the bit-sampling front end and the symbol consumer in the receive datapath.

## Interface
- `CNT_W`, default 8: width of the saturating parity-error counter.
- `ALARM_TH`, default 3: number of consecutive parity-errored symbols that raises `alarm`. Legal range 1..15.
- `clk`  in  1: single system clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `bitIn`  in  1: serial line sample. Idle level is 1.
- `bitValid`  in  1: `bitIn` is a new bit this cycle. All FSM progress occurs only on `bitValid` cycles.
- `errClr`  in  1: synchronous clear of `errCnt`, the consecutive counter and `alarm`.
- `symValid`  out  1: one-cycle pulse; a parity-checked symbol is presented.
- `symData`  out  7: data bits of the symbol, MSB first as received. Held until the next `symValid`.
- `symErr`  out  1: parity error on the presented symbol. Held with `symData`.
- `frameErr`  out  1: one-cycle pulse; the stop bit was sampled as 0.
- `errCnt`  out  CNT_W: count of parity-errored symbols, saturating.
- `alarm`  out  1: sticky consecutive-error alarm.

## Operation
- Frame format: start bit (0), then 8 symbol bits MSB first (`d6..d0`, then parity `p`), then stop bit (1).
- Odd parity: a symbol is good when the XOR of all 8 bits is 1. `symErr` = ~^symbol.
- FSM states and transitions:
  - IDLE: on a `bitValid` with `bitIn`=0, go to DATA and clear the bit index.
  - DATA: on each `bitValid`, shift `bitIn` into an 8-bit shift register and increment the index. After the 8th bit, go to STOP.
  - STOP: on `bitValid`:
    - `bitIn`=1: register the symbol, pulse `symValid`, go to IDLE.
    - `bitIn`=0: pulse `frameErr`, assert no `symValid`, leave `symData`, `symErr` and all counters unchanged, go to IDLE.
- A start bit directly after a stop bit is legal (back-to-back frames).
- Error statistics, updated on each `symValid` cycle:
  - `symErr`=1: `errCnt` increments, saturating at 2^CNT_W−1. The consecutive counter (4 bits, saturating at 15) increments.
  - `symErr`=0: the consecutive counter clears. `errCnt` holds.
  - `alarm` sets when the consecutive count reaches `ALARM_TH`. It remains set until `errClr` or reset.
- `errClr` coincident with an error update: the clear wins. Counters become 0 and `alarm` becomes 0 that cycle; the coincident error is discarded.
- `frameErr` does not affect `errCnt` or the consecutive counter.

## Timing
- Reset values: FSM=IDLE, index=0, shift register=0, `symValid`=0, `symData`=0, `symErr`=0, `frameErr`=0, `errCnt`=0, consecutive counter=0, `alarm`=0.
- Reset asserted mid-frame aborts the frame immediately. After reset deasserts, the FSM re-hunts from IDLE.
- Latency: `symValid`/`frameErr` are registered. They assert in the cycle after the clock edge that samples the stop bit.
- `symData`/`symErr` update in the same cycle `symValid` asserts.
- `errCnt` and `alarm` reflect a symbol one cycle after its `symValid`.
- Cycles without `bitValid` freeze the FSM. There is no timeout.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package `parity_pkg` holds:
  - the FSM state enum (IDLE, DATA, STOP);
  - the constants `SYM_W`=8, `DATA_W`=7, `IDLE_LVL`=1'b1.
- One sub-module, `parity_odd_chk`: combinational 8-bit odd-parity checker with output `isErr`. It is instantiated on the shift-register contents. No other hierarchy.

## Test plan
- Frame 0,1010101,0,1 (bitValid every cycle) -> one `symValid` pulse, `symData`=7'h55, `symErr`=1, `errCnt`=1.
- Frame 0,1010101,1,1 -> `symData`=7'h55, `symErr`=0. The consecutive counter clears and `errCnt` holds.
- Three back-to-back errored frames with `ALARM_TH`=3 -> `alarm`=1 after the third. A following good frame leaves `alarm`=1. `errClr` -> `alarm`=0, `errCnt`=0.
- Frame with stop bit 0 -> a `frameErr` pulse, no `symValid`, previous `symData` held, counters unchanged.
- `bitValid` toggling at a 1-in-4 rate while carrying frame 0,0000000,1,1 -> identical result to the full-rate case: `symData`=7'h00, `symErr`=0.
- `rst_n` pulsed low after 4 data bits, then a clean frame -> no output for the aborted frame. The clean frame is decoded correctly. With `CNT_W`=2, 5 errored frames -> `errCnt` saturates at 3.
